// File: rtl/dot_operand_feeder.sv
// dot_operand_feeder: streams row/vector chunks from two read RAMs to a dot-product stage
// Ports: clk; reset (synchronous, active-low);
//   start/total/row_base/vec_base      - begin a sequence of ceil(total/no_of_units) chunks
//   row_rd_addr/vec_rd_addr            - RAM read addresses (data returns one cycle later)
//   row_rd_data/vec_rd_data            - one full chunk per address
//   first_row_plus_additional/vector2  - registered operands, valid while outsider_read_now
//   I_am_ready                         - downstream accepts when high with outsider_read_now
//   busy/done                          - activity flag and end-of-sequence pulse
// Optional: define FEEDER_ZERO_PAD_EN to zero lanes whose element index is >= total.
module dot_operand_feeder #(
    parameter int element_width = 32,
    parameter int no_of_units   = 8,
    parameter int addr_width    = 10
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [31:0]                          total,
    input  logic [addr_width-1:0]                row_base,
    input  logic [addr_width-1:0]                vec_base,
    output logic [addr_width-1:0]                row_rd_addr,
    output logic [addr_width-1:0]                vec_rd_addr,
    input  logic [element_width*no_of_units-1:0] row_rd_data,
    input  logic [element_width*no_of_units-1:0] vec_rd_data,
    output logic [element_width*no_of_units-1:0] first_row_plus_additional,
    output logic [element_width*no_of_units-1:0] vector2,
    output logic                                 outsider_read_now,
    input  logic                                 I_am_ready,
    output logic                                 busy,
    output logic                                 done
);
    localparam int cw = element_width * no_of_units;
    typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, PRESENT, FINISH} state_t;
    state_t state, state_nx;
    logic [31:0] k, n_chunks;
    logic [addr_width-1:0] row_base_r, vec_base_r;
    logic [cw-1:0] row_cap, vec_cap;
    logic accept, last;
    assign accept = state == PRESENT && I_am_ready;
    assign last = k + 32'd1 >= n_chunks;
    assign busy = state != IDLE;
    assign done = state == FINISH;
    assign outsider_read_now = state == PRESENT;
    // Address is held through CAPTURE so an unregistered-output RAM also sees it stable.
    assign row_rd_addr = (state == FETCH || state == CAPTURE) ? row_base_r + addr_width'(k) : '0;
    assign vec_rd_addr = (state == FETCH || state == CAPTURE) ? vec_base_r + addr_width'(k) : '0;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = total != 32'd0 ? FETCH : FINISH;
            FETCH:   state_nx = CAPTURE;
            CAPTURE: state_nx = PRESENT;
            PRESENT: if (I_am_ready) state_nx = last ? FINISH : FETCH;
            FINISH:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
`ifdef FEEDER_ZERO_PAD_EN
    logic [31:0] total_r;
    always_ff @(posedge clk) begin
        if (!reset) total_r <= '0;
        else if (state == IDLE && start) total_r <= total;
    end
    // Only lanes of the last chunk can fall at or beyond total, so the test is uniform.
    always_comb begin
        row_cap = row_rd_data;
        vec_cap = vec_rd_data;
        for (int i = 0; i < no_of_units; i++)
            if (k * 32'(no_of_units) + 32'(i) >= total_r) begin
                row_cap[i*element_width +: element_width] = '0;
                vec_cap[i*element_width +: element_width] = '0;
            end
    end
`else
    assign row_cap = row_rd_data;
    assign vec_cap = vec_rd_data;
`endif
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            k <= '0;
            n_chunks <= '0;
            row_base_r <= '0;
            vec_base_r <= '0;
            first_row_plus_additional <= '0;
            vector2 <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                k <= '0;
                n_chunks <= total / 32'(no_of_units) + {31'd0, |(total % 32'(no_of_units))};
                row_base_r <= row_base;
                vec_base_r <= vec_base;
            end
            if (accept) k <= k + 32'd1;
            if (state == CAPTURE) begin
                first_row_plus_additional <= row_cap;
                vector2 <= vec_cap;
            end
        end
    end
endmodule
